// File: rtl/rvh_l1d_pkg.sv
// Shared L1D bank geometry and the eviction-reader FSM state encoding.
package rvh_l1d_pkg;

  localparam int unsigned L1D_BANK_WAY_NUM          = 4;
  localparam int unsigned L1D_BANK_WAY_IDX_WIDTH    = $clog2(L1D_BANK_WAY_NUM);
  localparam int unsigned L1D_BANK_SET_NUM          = 64;
  localparam int unsigned L1D_BANK_SET_INDEX_WIDTH  = $clog2(L1D_BANK_SET_NUM);
  localparam int unsigned L1D_BANK_LINE_ADDR_SIZE   = 26;
  localparam int unsigned L1D_BANK_LINE_DATA_SIZE   = 512;
  localparam int unsigned L1D_BANK_ID_MAX           = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    PUSH  = 2'd3
  } evict_state_e;

endpackage

// File: rtl/rvh_l1d_evict_reader.sv
// Reads a dirty victim line chunk by chunk from the L1D data RAM and hands the
// assembled line to the eviction write queue.
module rvh_l1d_evict_reader
  import rvh_l1d_pkg::*;
#(
  parameter int unsigned BANK_ID = 0,
  parameter int unsigned N_CHUNK = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        evict_req_valid_i,
  input  logic [L1D_BANK_LINE_ADDR_SIZE-1:0]          evict_req_addr_i,
  input  logic [L1D_BANK_WAY_IDX_WIDTH-1:0]           evict_req_way_i,
  output logic                                        evict_req_ready_o,
  output logic                                        ram_rd_en_o,
  output logic [L1D_BANK_WAY_IDX_WIDTH-1:0]           ram_rd_way_o,
  output logic [L1D_BANK_SET_INDEX_WIDTH-1:0]         ram_rd_set_o,
  output logic [$clog2(N_CHUNK)-1:0]                  ram_rd_chunk_o,
  input  logic                                        ram_rd_gnt_i,
  input  logic [L1D_BANK_LINE_DATA_SIZE/N_CHUNK-1:0]  ram_rd_data_i,
  output logic                                        ewrq_valid_o,
  output logic [L1D_BANK_LINE_ADDR_SIZE-1:0]          ewrq_addr_o,
  output logic [L1D_BANK_LINE_DATA_SIZE-1:0]          ewrq_dat_o,
  input  logic                                        ewrq_ready_i,
  input  logic [L1D_BANK_LINE_ADDR_SIZE-1:0]          lookup_addr_i,
  output logic                                        lookup_hit_o
);

  localparam int unsigned CHUNK_W = L1D_BANK_LINE_DATA_SIZE / N_CHUNK;
  localparam int unsigned CNT_W   = $clog2(N_CHUNK);

  // Elaboration-time parameter sanity.
  if (N_CHUNK < 2 || (N_CHUNK & (N_CHUNK - 1)) != 0) begin : g_bad_n_chunk
    $error("N_CHUNK must be a power of two >= 2");
  end
  if (BANK_ID > L1D_BANK_ID_MAX) begin : g_bad_bank_id
    $error("BANK_ID out of range");
  end

  evict_state_e                          state_q;
  evict_state_e                          state_d;
  logic [L1D_BANK_LINE_ADDR_SIZE-1:0]    addr_q;
  logic [L1D_BANK_WAY_IDX_WIDTH-1:0]     way_q;
  logic [CNT_W-1:0]                      cnt_q;
  logic                                  dv_q;
  logic [CNT_W-1:0]                      dv_idx_q;
  logic [L1D_BANK_LINE_DATA_SIZE-1:0]    line_q;
  logic                                  accept;
  logic                                  rd_fire;

  // Next-state and handshake decode.
  always_comb begin
    state_d           = state_q;
    evict_req_ready_o = 1'b0;
    ram_rd_en_o       = 1'b0;
    ewrq_valid_o      = 1'b0;
    accept            = 1'b0;
    rd_fire           = 1'b0;
    case (state_q)
      IDLE: begin
        evict_req_ready_o = 1'b1;
        if (evict_req_valid_i) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        ram_rd_en_o = 1'b1;
        if (ram_rd_gnt_i) begin
          rd_fire = 1'b1;
          if (cnt_q == CNT_W'(N_CHUNK - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = PUSH;
      end
      PUSH: begin
        ewrq_valid_o = 1'b1;
        if (ewrq_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, chunk counter, one-cycle data-valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= rd_fire;
      if (accept) begin
        cnt_q <= '0;
      end else if (rd_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath: request latch and line assembly; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= evict_req_addr_i;
      way_q  <= evict_req_way_i;
    end
    if (rd_fire) begin
      dv_idx_q <= cnt_q;
    end
    for (int unsigned i = 0; i < N_CHUNK; i++) begin
      if (dv_q && dv_idx_q == CNT_W'(i)) begin
        line_q[i*CHUNK_W +: CHUNK_W] <= ram_rd_data_i;
      end
    end
  end

  assign ram_rd_way_o   = way_q;
  assign ram_rd_set_o   = addr_q[L1D_BANK_SET_INDEX_WIDTH-1:0];
  assign ram_rd_chunk_o = cnt_q;
  assign ewrq_addr_o    = addr_q;
  assign ewrq_dat_o     = line_q;
  assign lookup_hit_o   = (state_q != IDLE) && (lookup_addr_i == addr_q);

endmodule
